// File: rtl/alu.sv
// 16-bit signed ALU for the myMIPS datapath: eight operations selected by cmd,
// combinational result/equality/overflow, plus a registered sticky overflow bit.
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] OP1,
   input  logic [15:0] OP2,
   input  logic [2:0]  cmd,
   output logic [15:0] RES,
   output logic        eq_bit,
   output logic        ovF,
   output logic        ovf_sticky
);

   typedef enum logic [2:0] {
      CMD_ADD = 3'b000,
      CMD_SUB = 3'b001,
      CMD_SLL = 3'b010,
      CMD_GT  = 3'b011,
      CMD_SRL = 3'b100,
      CMD_AND = 3'b101,
      CMD_OR  = 3'b110,
      CMD_EQ  = 3'b111
   } cmd_e;

   logic [15:0] sum;
   logic [15:0] diff;
   logic [15:0] sll_res;
   logic [15:0] srl_res;
   logic        add_ovf;
   logic        sub_ovf;
   logic        shift_big;
   logic        gt;

   always_comb begin
      sum  = OP1 + OP2;
      diff = OP1 - OP2;
      // Signed overflow: result sign disagrees with what the operand signs allow.
      add_ovf = (OP1[15] == OP2[15]) && (sum[15] != OP1[15]);
      sub_ovf = (OP1[15] != OP2[15]) && (diff[15] != OP1[15]);
      // OP2 is an unsigned shift amount; anything 16 or above (negative included) flushes to zero.
      shift_big = |OP2[15:4];
      sll_res   = shift_big ? 16'd0 : (OP1 << OP2[3:0]);
      srl_res   = shift_big ? 16'd0 : (OP1 >> OP2[3:0]);
      gt        = $signed(OP1) > $signed(OP2);
      eq_bit    = (OP1 == OP2);
   end

   always_comb begin
      RES = 16'd0;
      ovF = 1'b0;
      case (cmd_e'(cmd))
         CMD_ADD: begin
            RES = sum;
            ovF = add_ovf;
         end
         CMD_SUB: begin
            RES = diff;
            ovF = sub_ovf;
         end
         CMD_SLL: RES = sll_res;
         CMD_SRL: RES = srl_res;
         CMD_GT:  RES = {15'd0, gt};
         CMD_EQ:  RES = {15'd0, eq_bit};
         CMD_AND: RES = OP1 & OP2;
         CMD_OR:  RES = OP1 | OP2;
         default: begin
            RES = 16'd0;
            ovF = 1'b0;
         end
      endcase
   end

   // Reset wins over a coincident overflow.
   always_ff @(posedge clk) begin
      if (rst) ovf_sticky <= 1'b0;
      else     ovf_sticky <= ovf_sticky | ovF;
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary table, sticky-flag sequence and a
// randomized sweep, all checked against an integer-arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [15:0] OP1;
   logic [15:0] OP2;
   logic [2:0]  cmd;
   logic [15:0] RES;
   logic        eq_bit;
   logic        ovF;
   logic        ovf_sticky;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic        sticky_m;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLL = 3'b010, GT = 3'b011,
                          SRL = 3'b100, AND_ = 3'b101, OR_ = 3'b110, EQ = 3'b111;

   alu dut (
      .clk(clk), .rst(rst), .OP1(OP1), .OP2(OP2), .cmd(cmd),
      .RES(RES), .eq_bit(eq_bit), .ovF(ovF), .ovf_sticky(ovf_sticky)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (OP1=%h OP2=%h cmd=%b)", tag, got, exp, OP1, OP2, cmd);
      end
   endtask

   // Reference model in plain integer arithmetic.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                        output logic [15:0] res, output logic eq, output logic ovf);
      longint sa, sb, ua, ub, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      ovf = 1'b0;
      eq  = (sa == sb);
      r   = 0;
      case (c)
         ADD: begin r = sa + sb; ovf = (r > 32767) || (r < -32768); end
         SUB: begin r = sa - sb; ovf = (r > 32767) || (r < -32768); end
         SLL: r = (ub >= 16) ? 0 : (ua * (longint'(1) << ub)) % 65536;
         SRL: r = (ub >= 16) ? 0 : ua / (longint'(1) << ub);
         GT:  r = (sa > sb) ? 1 : 0;
         EQ:  r = (sa == sb) ? 1 : 0;
         AND_: r = longint'(a & b);
         default: r = longint'(a | b);
      endcase
      res = 16'(r & 64'hFFFF);
   endtask

   // driver: apply one cycle, check combinational outputs, then the sticky bit after the edge
   task automatic cycle(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                        input logic r);
      logic [15:0] e_res;
      logic        e_eq;
      logic        e_ovf;
      logic        e_sticky;
      @(negedge clk);
      OP1 = a; OP2 = b; cmd = c; rst = r;
      #1;
      model(a, b, c, e_res, e_eq, e_ovf);
      check("res", RES, e_res);
      check("eq_bit", 16'(eq_bit), 16'(e_eq));
      check("ovF", 16'(ovF), 16'(e_ovf));
      e_sticky = r ? 1'b0 : (sticky_m | e_ovf);
      exp_q.push_back(16'(e_sticky));
      @(posedge clk);
      #1;
      sticky_m = e_sticky;
      check("ovf_sticky", 16'(ovf_sticky), exp_q.pop_front());
   endtask

   initial begin
      logic [15:0] a, b;
      logic [2:0]  c;
      OP1 = 16'd0; OP2 = 16'd0; cmd = ADD; rst = 1'b1;
      sticky_m = 1'b0;

      // reset
      cycle(16'h0000, 16'h0000, ADD, 1'b1);
      check("reset_sticky", 16'(ovf_sticky), 16'd0);

      // directed boundary table
      cycle(16'h7FFF, 16'h0001, ADD, 1'b0);
      check("add_ovf_res", RES, 16'h8000);
      check("add_ovf_flag", 16'(ovF), 16'd1);
      check("sticky_set", 16'(ovf_sticky), 16'd1);
      cycle(16'h0001, 16'h0001, ADD, 1'b0);
      check("sticky_hold", 16'(ovf_sticky), 16'd1);
      cycle(16'd100, -16'sd30, ADD, 1'b0);
      check("add_70", RES, 16'd70);
      cycle(16'h8000, 16'h0001, SUB, 1'b0);
      check("sub_ovf_res", RES, 16'h7FFF);
      cycle(-16'sd5, -16'sd5, SUB, 1'b0);
      check("sub_zero_eq", 16'(eq_bit), 16'd1);
      cycle(16'h0001, 16'd15, SLL, 1'b0);
      check("sll15", RES, 16'h8000);
      cycle(16'h8000, 16'd15, SRL, 1'b0);
      check("srl15", RES, 16'h0001);
      cycle(16'hF000, 16'd4, SRL, 1'b0);
      check("srl4", RES, 16'h0F00);
      cycle(16'h1234, 16'd16, SLL, 1'b0);
      check("sll16", RES, 16'h0000);
      cycle(16'hABCD, 16'hFFFF, SRL, 1'b0);
      cycle(16'hABCD, 16'd0, SLL, 1'b0);
      check("sll0", RES, 16'hABCD);
      cycle(16'hFFFF, 16'h0001, GT, 1'b0);
      check("gt_neg", RES, 16'd0);
      cycle(16'h0001, 16'hFFFF, GT, 1'b0);
      check("gt_pos", RES, 16'd1);
      cycle(16'd7, 16'd7, GT, 1'b0);
      cycle(16'h1234, 16'h1234, EQ, 1'b0);
      cycle(16'h1234, 16'h1235, EQ, 1'b0);
      cycle(16'h0F0F, 16'h00FF, AND_, 1'b0);
      check("and", RES, 16'h000F);
      cycle(16'h0F0F, 16'h00FF, OR_, 1'b0);
      check("or", RES, 16'h0FFF);

      // reset coincident with a fresh overflow
      cycle(16'h7FFF, 16'h0001, ADD, 1'b1);
      check("rst_over_ovf", 16'(ovf_sticky), 16'd0);

      // randomized sweep with boundary-biased operands
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: a = 16'h7FFF;
            1: a = 16'h8000;
            default: a = 16'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: b = a;
            1: b = 16'($urandom_range(0, 20));
            2: b = 16'h8000;
            default: b = 16'($urandom);
         endcase
         c = 3'($urandom_range(0, 7));
         cycle(a, b, c, ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout got=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

16-bit signed arithmetic/logic unit for the myMIPS datapath. Computes one of eight operations on two 16-bit two's-complement operands, selected by a 3-bit command, and returns a 16-bit result plus an equality flag and a signed-overflow flag combinationally. A single clocked register holds a sticky overflow status for the control path; it is the block's only state.

## Interface

- No parameters; data width fixed at 16, command width fixed at 3.
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock; the sticky register updates on its rising edge.
- rst  in  1  synchronous active-high reset; clears ovf_sticky.
- OP1  in  16  operand 1, signed two's complement.
- OP2  in  16  operand 2, signed two's complement; shift amount for shifts.
- cmd  in  3  operation select.
- RES  out  16  result, combinational.
- eq_bit  out  1  1 when OP1 == OP2, combinational, independent of cmd.
- ovF  out  1  signed overflow of the current add/sub, combinational.
- ovf_sticky  out  1  registered OR of ovF since last reset.

## Operation

- cmd encoding:
  - 000 ADD: RES = (OP1 + OP2) mod 2^16.
  - 001 SUB: RES = (OP1 − OP2) mod 2^16.
  - 010 SLL: RES = OP1 << OP2, zero fill.
  - 100 SRL: RES = OP1 >> OP2, logical; zero fill, no sign extension.
  - 011 GT: RES = 16'd1 if OP1 > OP2 (signed compare), else 16'd0.
  - 111 EQ: RES = 16'd1 if OP1 == OP2, else 16'd0.
  - 101 AND: RES = OP1 & OP2, bitwise.
  - 110 OR: RES = OP1 | OP2, bitwise.
- Shift amount:
  - OP2 is treated as unsigned.
  - If OP2 ≥ 16, including any negative OP2, RES = 0 for both SLL and SRL.
  - Shift by 0 returns OP1 unchanged.
- ovF:
  - ADD: 1 when both operands have equal sign bits and RES sign differs.
  - SUB: 1 when operand sign bits differ and RES sign differs from OP1.
  - All other commands: 0.
- eq_bit is valid for every cmd value.
- No undefined cmd codes exist; all 8 are assigned.
- No X propagation from cmd: every output is driven for every input combination.

## Timing

- RES, eq_bit and ovF are purely combinational from OP1, OP2 and cmd.
  - Zero-cycle latency: valid in the same cycle the inputs change, before the next rising edge.
  - Unaffected by clk and rst.
- ovf_sticky, on each rising clk edge:
  - rst = 1 → 0. Reset has priority over a simultaneous ovF = 1.
  - Otherwise it becomes ovf_sticky | ovF.
- ovf_sticky reset value is 0. It is the only output with a reset value.
- It reflects an overflow one cycle after the cycle in which ovF was high.
- Reset asserted mid-sequence clears only ovf_sticky; the combinational path continues computing.
- Operands are sampled by the downstream consumer; the block has no handshake and no enable.

## Test plan

- ADD boundaries:
  - OP1 = 0x7FFF, OP2 = 0x0001, cmd = 000 → RES = 0x8000, ovF = 1, eq_bit = 0.
  - OP1 = 100, OP2 = −30 → RES = 70, ovF = 0.
- SUB boundaries:
  - OP1 = 0x8000, OP2 = 0x0001, cmd = 001 → RES = 0x7FFF, ovF = 1.
  - OP1 = −5, OP2 = −5 → RES = 0, ovF = 0, eq_bit = 1.
- Shifts:
  - SLL, OP1 = 0x0001, OP2 = 15 → RES = 0x8000.
  - SRL, OP1 = 0x8000, OP2 = 15 → RES = 0x0001 (logical shift).
  - SRL, OP1 = 0xF000, OP2 = 4 → RES = 0x0F00.
  - SLL, OP1 = 0x1234, OP2 = 16 → RES = 0.
  - SLL, OP2 = 0 → RES = OP1.
- Compares:
  - GT, OP1 = −1, OP2 = 1 → RES = 0.
  - GT, OP1 = 1, OP2 = −1 → RES = 1.
  - GT, OP1 = OP2 = 7 → RES = 0.
  - EQ, OP1 = OP2 = 0x1234 → RES = 1, eq_bit = 1.
  - EQ, OP1 = 0x1234, OP2 = 0x1235 → RES = 0, eq_bit = 0.
- Logic:
  - AND, OP1 = 0x0F0F, OP2 = 0x00FF → RES = 0x000F.
  - OR, same operands → RES = 0x0FFF.
  - ovF = 0 for both.
- Sticky flag:
  - rst for 1 cycle → ovf_sticky = 0.
  - Apply ADD 0x7FFF + 1 for one cycle, then ADD 1 + 1 → ovf_sticky = 1 from the edge after the overflow cycle, and it stays 1.
  - Assert rst in the same cycle as a new overflow → ovf_sticky = 0 after that edge.
  - Randomized sweep over all 8 cmds: RES and eq_bit match a 16-bit signed reference model every cycle.
